// File: rtl/ped_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ped_pkg
//  Description : Shared types and constants for the pedestrian crossing
//                controller: FSM state encoding, default timing values and
//                the countdown width.
//  Revision    : 1.0  initial release
// ============================================================================
package ped_pkg;

  // Width of the clearance countdown output (FLASH_TIME must fit in it).
  localparam int COUNT_W = 5;

  // Default timing, in clock cycles.
  localparam int c_WALK_TIME_DEFAULT    = 8;
  localparam int c_FLASH_TIME_DEFAULT   = 8;
  localparam int c_BLINK_HALF_DEFAULT   = 2;
  localparam int c_CHIRP_PERIOD_DEFAULT = 4;

  // Length of the upstream vehicle red phase at its default settings. The
  // whole WALK + FLASH sequence plus the entry cycle must fit inside it.
  localparam int c_UPSTREAM_RED_TIME    = 21;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WALK  = 3'd1,
    ST_FLASH = 3'd2,
    ST_CLEAR = 3'd3,
    ST_FAULT = 3'd4
  } ped_state_t;

  // Exactly one of the three vehicle lamps must be lit.
  function automatic logic lamps_one_hot(input logic [2:0] lamps);
    return (lamps == 3'b100) || (lamps == 3'b010) || (lamps == 3'b001);
  endfunction

endpackage : ped_pkg
`default_nettype wire

// File: rtl/ped_button_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ped_button_sync
//  Description : Two-flop synchroniser for the raw pedestrian push-button,
//                followed by a rising-edge detector producing a one-cycle
//                pulse 2-3 cycles after the pin edge.
//  Ports       : clk        - system clock
//                reset      - asynchronous, active-high reset
//                button_raw - asynchronous push-button input
//                rise_pulse - one-cycle pulse on a synchronised rising edge
//  Revision    : 1.0  initial release
// ============================================================================
module ped_button_sync (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic rise_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
    end else begin
      r_sync1   <= button_raw;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  assign rise_pulse = r_sync2 & ~r_sync2_d;

endmodule : ped_button_sync
`default_nettype wire

// File: rtl/ped_signal_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ped_signal_controller
//  Description : Pedestrian crossing stage fed by the vehicle lamp outputs.
//                Latches push-button requests, grants WALK only inside the
//                vehicle red phase, then flashes DON'T WALK with a clearance
//                countdown. Unsafe lamp inputs force a sticky fault state
//                that only reset clears.
//  Options     : PED_AUDIO_EN - adds the chirp output (audio pulses in WALK
//                and on every DON'T WALK rise in FLASH).
//  Ports       : clk, reset            - clock, async active-high reset
//                green, yellow, red    - vehicle lamps (one-hot)
//                ped_button            - raw push-button
//                walk, dont_walk       - pedestrian lamps (registered)
//                countdown             - remaining FLASH cycles, 0 elsewhere
//                req_pending           - latched request awaiting service
//                fault                 - sticky lamp-input fault
//                chirp                 - audio pulse (PED_AUDIO_EN only)
//  Revision    : 1.0  initial release
// ============================================================================
module ped_signal_controller
  import ped_pkg::*;
#(
  parameter int WALK_TIME    = c_WALK_TIME_DEFAULT,
  parameter int FLASH_TIME   = c_FLASH_TIME_DEFAULT,
  parameter int BLINK_HALF   = c_BLINK_HALF_DEFAULT,
  parameter int CHIRP_PERIOD = c_CHIRP_PERIOD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               green,
  input  logic               yellow,
  input  logic               red,
  input  logic               ped_button,
  output logic               walk,
  output logic               dont_walk,
  output logic [COUNT_W-1:0] countdown,
  output logic               req_pending,
  output logic               fault
`ifdef PED_AUDIO_EN
  ,
  output logic               chirp
`endif
);

  localparam logic [7:0]         c_WALK_LAST  = 8'(WALK_TIME - 1);
  localparam logic [COUNT_W-1:0] c_FLASH_INIT = COUNT_W'(FLASH_TIME);
  localparam logic [3:0]         c_BLINK_LAST = 4'(BLINK_HALF - 1);

  ped_state_t       r_state;
  logic             r_red_d;
  logic [7:0]       r_walk_timer;
  logic [3:0]       r_blink_cnt;

  logic             w_btn_edge;
  logic             w_red_rise;
  logic             w_fault_cond;
  logic             w_walk_start;

  ped_button_sync u_button_sync (
    .clk        (clk),
    .reset      (reset),
    .button_raw (ped_button),
    .rise_pulse (w_btn_edge)
  );

  // r_red_d resets to 1 so a red phase already running at reset release is
  // not mistaken for a fresh rise.
  assign w_red_rise   = red & ~r_red_d;
  assign w_walk_start = (r_state == ST_IDLE) && w_red_rise && req_pending;

  // Losing red while pedestrians may be crossing is as unsafe as a broken
  // lamp encoding. Staying in FAULT is folded in here so it always wins.
  assign w_fault_cond = (r_state == ST_FAULT)
                     || !lamps_one_hot({green, yellow, red})
                     || (!red && ((r_state == ST_WALK) || (r_state == ST_FLASH)));

  // Outputs are registered alongside the state, from the state being
  // entered, so each appears in the first cycle of that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_red_d      <= 1'b1;
      r_walk_timer <= '0;
      r_blink_cnt  <= '0;
      walk         <= 1'b0;
      dont_walk    <= 1'b1;
      countdown    <= '0;
      req_pending  <= 1'b0;
      fault        <= 1'b0;
    end else begin
      r_red_d <= red;
      if (w_fault_cond) begin
        r_state     <= ST_FAULT;
        walk        <= 1'b0;
        dont_walk   <= 1'b1;
        countdown   <= '0;
        req_pending <= 1'b0;
        fault       <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_walk_start) begin
              r_state      <= ST_WALK;
              req_pending  <= 1'b0;
              walk         <= 1'b1;
              dont_walk    <= 1'b0;
              r_walk_timer <= c_WALK_LAST;
            end else begin
              // Without a pending request this red phase is not served; a
              // button edge on the rise itself waits for the next phase.
              if (w_red_rise) r_state <= ST_CLEAR;
              if (w_btn_edge) req_pending <= 1'b1;
            end
          end

          ST_WALK: begin
            if (r_walk_timer == 8'd0) begin
              r_state     <= ST_FLASH;
              walk        <= 1'b0;
              dont_walk   <= 1'b1;
              countdown   <= c_FLASH_INIT;
              r_blink_cnt <= '0;
            end else begin
              r_walk_timer <= r_walk_timer - 8'd1;
            end
          end

          ST_FLASH: begin
            // countdown doubles as the FLASH timer: it reads 1 on the last cycle.
            if (countdown == COUNT_W'(1)) begin
              r_state   <= ST_CLEAR;
              countdown <= '0;
              dont_walk <= 1'b1;
            end else begin
              countdown <= countdown - COUNT_W'(1);
              if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                dont_walk   <= ~dont_walk;
              end else begin
                r_blink_cnt <= r_blink_cnt + 4'd1;
              end
            end
          end

          ST_CLEAR: begin
            if (!red) r_state <= ST_IDLE;
            if (w_btn_edge) req_pending <= 1'b1;
          end

          default: begin
            r_state <= ST_FAULT;
            fault   <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef PED_AUDIO_EN
  localparam logic [3:0] c_CHIRP_LAST = 4'(CHIRP_PERIOD - 1);

  logic [3:0] r_chirp_cnt;
  logic       w_chirp_next;

  // Chirp tracks the same next-state decisions as the lamps: a pulse on WALK
  // entry and every CHIRP_PERIOD cycles after, and on each dont_walk rise in
  // FLASH (including the FLASH entry, where dont_walk comes back on).
  always_comb begin
    w_chirp_next = 1'b0;
    if (!w_fault_cond) begin
      case (r_state)
        ST_IDLE:  w_chirp_next = w_walk_start;
        ST_WALK:  w_chirp_next = (r_walk_timer == 8'd0) || (r_chirp_cnt == c_CHIRP_LAST);
        ST_FLASH: w_chirp_next = (countdown != COUNT_W'(1)) && (r_blink_cnt == c_BLINK_LAST)
                                 && !dont_walk;
        default:  w_chirp_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chirp       <= 1'b0;
      r_chirp_cnt <= '0;
    end else begin
      chirp <= w_chirp_next;
      if (r_state != ST_WALK || r_chirp_cnt == c_CHIRP_LAST) begin
        r_chirp_cnt <= '0;
      end else begin
        r_chirp_cnt <= r_chirp_cnt + 4'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Parameter sanity plus the integration rule that the whole crossing fits
  // in one upstream red phase.
  localparam bit c_PARAMS_OK = (WALK_TIME >= 1) && (WALK_TIME <= 256)
                            && (FLASH_TIME >= 1) && (FLASH_TIME <= 31)
                            && (BLINK_HALF >= 1) && (BLINK_HALF <= 16)
                            && (CHIRP_PERIOD >= 1) && (CHIRP_PERIOD <= 16)
                            && (WALK_TIME + FLASH_TIME + 1 <= c_UPSTREAM_RED_TIME);

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (c_PARAMS_OK)
        else $error("ped_signal_controller: timing parameters out of range or exceed upstream red");
    end
  end
`endif

endmodule : ped_signal_controller
`default_nettype wire

// File: tb/tb_ped_signal_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ped_signal_controller
//  Description : Directed self-checking bench for ped_signal_controller.
//                Inputs change on the falling edge, outputs are sampled on
//                the falling edge, half a cycle away from the active edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ped_signal_controller;

  logic       clk;
  logic       reset;
  logic       green;
  logic       yellow;
  logic       red;
  logic       ped_button;
  logic       walk;
  logic       dont_walk;
  logic [4:0] countdown;
  logic       req_pending;
  logic       fault;
`ifdef PED_AUDIO_EN
  logic       chirp;
`endif

  int checks = 0;
  int errors = 0;

  // Observed output bundle: {walk, dont_walk, countdown, req_pending, fault}
  wire [8:0] obs = {walk, dont_walk, countdown, req_pending, fault};

  localparam logic [8:0] c_RESET_VEC = {1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
  localparam logic [8:0] c_FAULT_VEC = {1'b0, 1'b1, 5'd0, 1'b0, 1'b1};
  // Expected dont_walk over the 8 FLASH cycles, first cycle leftmost.
  localparam logic [0:7] c_DW_PAT    = 8'b1100_1100;

  ped_signal_controller dut (
    .clk         (clk),
    .reset       (reset),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .ped_button  (ped_button),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .req_pending (req_pending),
    .fault       (fault)
`ifdef PED_AUDIO_EN
    ,
    .chirp       (chirp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lamps(input logic g, input logic y, input logic r);
    green  = g;
    yellow = y;
    red    = r;
  endtask

  task automatic press(input int n);
    ped_button = 1'b1;
    step(n);
    ped_button = 1'b0;
  endtask

  task automatic do_reset(input logic g, input logic y, input logic r);
    reset      = 1'b1;
    ped_button = 1'b0;
    set_lamps(g, y, r);
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Press during green, go through yellow and into red; returns at the
  // first WALK cycle.
  task automatic enter_walk();
    press(4);
    step(2);
    set_lamps(1'b0, 1'b1, 1'b0);
    step(2);
    set_lamps(1'b0, 1'b0, 1'b1);
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ped_button = 1'b0;
    set_lamps(1'b1, 1'b0, 1'b0);
    step(2);
    checks++;
    if (obs !== c_RESET_VEC) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", obs, c_RESET_VEC);
    end
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i < 4)       set_lamps(1'b1, 1'b0, 1'b0);
      else if (i < 6)  set_lamps(1'b0, 1'b1, 1'b0);
      else if (i < 12) set_lamps(1'b0, 1'b0, 1'b1);
      else             set_lamps(1'b1, 1'b0, 1'b0);
      step(1);
      checks++;
      if (obs !== c_RESET_VEC) begin
        errors++;
        $display("FAIL idle_cycle[%0d]: got %b expected %b", i, obs, c_RESET_VEC);
      end
    end
  endtask

  task automatic test_reset_in_red();
    logic [8:0] exp;
    do_reset(1'b0, 1'b0, 1'b1);
    press(4);
    step(1);
    exp = {1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL red_at_reset_req: got %b expected %b", obs, exp);
    end
    step(5);
    checks++;
    if (walk !== 1'b0) begin
      errors++;
      $display("FAIL red_at_reset_no_walk: got walk=%b expected 0", walk);
    end
    set_lamps(1'b1, 1'b0, 1'b0);
    step(1);
    set_lamps(1'b0, 1'b1, 1'b0);
    step(2);
    set_lamps(1'b0, 1'b0, 1'b1);
    step(1);
    exp = {1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL red_at_reset_served: got %b expected %b", obs, exp);
    end
  endtask

  task automatic test_walk_cycle();
    logic [8:0] exp;
    do_reset(1'b1, 1'b0, 1'b0);
    step(2);
    press(4);
    step(2);
    exp = {1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL req_latched: got %b expected %b", obs, exp);
    end
    set_lamps(1'b0, 1'b1, 1'b0);
    step(2);
    set_lamps(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      exp = {1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL walk_cycle[%0d]: got %b expected %b", i, obs, exp);
      end
`ifdef PED_AUDIO_EN
      checks++;
      if (chirp !== ((i == 1) || (i == 5))) begin
        errors++;
        $display("FAIL walk_chirp[%0d]: got %b expected %b", i, chirp, (i == 1) || (i == 5));
      end
`endif
    end
    for (int i = 1; i <= 8; i++) begin
      step(1);
      exp = {1'b0, c_DW_PAT[i-1], 5'(9 - i), 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL flash_cycle[%0d]: got %b expected %b", i, obs, exp);
      end
`ifdef PED_AUDIO_EN
      checks++;
      if (chirp !== ((i == 1) || (i == 5))) begin
        errors++;
        $display("FAIL flash_chirp[%0d]: got %b expected %b", i, chirp, (i == 1) || (i == 5));
      end
`endif
    end
    step(1);
    checks++;
    if (obs !== c_RESET_VEC) begin
      errors++;
      $display("FAIL clear_after_flash: got %b expected %b", obs, c_RESET_VEC);
    end
`ifdef PED_AUDIO_EN
    checks++;
    if (chirp !== 1'b0) begin
      errors++;
      $display("FAIL clear_chirp: got %b expected 0", chirp);
    end
`endif
    step(4);
    set_lamps(1'b1, 1'b0, 1'b0);
    step(2);
    checks++;
    if (obs !== c_RESET_VEC) begin
      errors++;
      $display("FAIL idle_after_red: got %b expected %b", obs, c_RESET_VEC);
    end
  endtask

  task automatic test_button_phases();
    logic [8:0] exp;
    do_reset(1'b1, 1'b0, 1'b0);
    enter_walk();
    step(1);
    press(4);
    step(2);
    exp = {1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL button_in_walk_ignored: got %b expected %b", obs, exp);
    end
    step(9);
    checks++;
    if (obs !== c_RESET_VEC) begin
      errors++;
      $display("FAIL clear_no_req: got %b expected %b", obs, c_RESET_VEC);
    end
    press(3);
    exp = {1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL button_in_clear_latched: got %b expected %b", obs, exp);
    end
    step(1);
    set_lamps(1'b1, 1'b0, 1'b0);
    step(3);
    checks++;
    if (req_pending !== 1'b1 || walk !== 1'b0) begin
      errors++;
      $display("FAIL req_held_in_green: got req=%b walk=%b expected req=1 walk=0", req_pending, walk);
    end
    set_lamps(1'b0, 1'b1, 1'b0);
    step(2);
    set_lamps(1'b0, 1'b0, 1'b1);
    step(1);
    exp = {1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clear_req_served: got %b expected %b", obs, exp);
    end
  endtask

  task automatic test_fault_one_hot();
    do_reset(1'b1, 1'b0, 1'b0);
    step(2);
    set_lamps(1'b1, 1'b0, 1'b1);
    step(1);
    set_lamps(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== c_FAULT_VEC) begin
      errors++;
      $display("FAIL fault_two_hot: got %b expected %b", obs, c_FAULT_VEC);
    end
    step(5);
    checks++;
    if (obs !== c_FAULT_VEC) begin
      errors++;
      $display("FAIL fault_sticky: got %b expected %b", obs, c_FAULT_VEC);
    end
    press(4);
    step(2);
    checks++;
    if (obs !== c_FAULT_VEC) begin
      errors++;
      $display("FAIL fault_button_ignored: got %b expected %b", obs, c_FAULT_VEC);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== c_RESET_VEC) begin
      errors++;
      $display("FAIL fault_cleared_by_reset: got %b expected %b", obs, c_RESET_VEC);
    end
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_red_drop();
    do_reset(1'b1, 1'b0, 1'b0);
    enter_walk();
    step(2);
    checks++;
    if (walk !== 1'b1) begin
      errors++;
      $display("FAIL walk_cycle3: got walk=%b expected 1", walk);
    end
    set_lamps(1'b1, 1'b0, 1'b0);
    step(1);
    checks++;
    if (obs !== c_FAULT_VEC) begin
      errors++;
      $display("FAIL red_drop_fault: got %b expected %b", obs, c_FAULT_VEC);
    end
  endtask

  task automatic test_reset_mid_flash();
    logic [8:0] exp;
    do_reset(1'b1, 1'b0, 1'b0);
    enter_walk();
    step(10);
    exp = {1'b0, 1'b0, 5'd6, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL flash_cycle3_before_reset: got %b expected %b", obs, exp);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== c_RESET_VEC) begin
      errors++;
      $display("FAIL reset_mid_flash: got %b expected %b", obs, c_RESET_VEC);
    end
`ifdef PED_AUDIO_EN
    checks++;
    if (chirp !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_flash_chirp: got %b expected 0", chirp);
    end
`endif
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    reset      = 1'b1;
    ped_button = 1'b0;
    set_lamps(1'b1, 1'b0, 1'b0);
    test_reset();
    test_reset_in_red();
    test_walk_cycle();
    test_button_phases();
    test_fault_one_hot();
    test_red_drop();
    test_reset_mid_flash();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ped_signal_controller
`default_nettype wire
